// File: rtl/ad_ip_jesd204_tpl_dac_dma_buffer_pkg.sv
// Shared TPL DAC definitions: DMA buffer playout states and the saturation limit for the
// underflow event counter.
package ad_ip_jesd204_tpl_dac_dma_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } dma_buf_state_t;

  localparam logic [31:0] UNDERFLOW_CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == UNDERFLOW_CNT_MAX) begin
      sat_inc32 = value;
    end else begin
      sat_inc32 = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_dma_buffer_mem.sv
// Simple dual-port storage for the DAC DMA buffer: one synchronous write port and one
// asynchronous read port, so the head word is visible in the same cycle it is addressed.
module ad_ip_jesd204_tpl_dac_dma_buffer_mem #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];

  // Write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_dma_buffer.sv
// DMA-to-TPL DAC playout buffer: FWFT FIFO with prefill gating, underflow detection and a
// saturating underflow counter.
module ad_ip_jesd204_tpl_dac_dma_buffer
  import ad_ip_jesd204_tpl_dac_dma_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH_LOG2 = 4,
  parameter int PREFILL    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  dac_valid,
  input  logic                  dac_rst,
  output logic [DATA_WIDTH-1:0] dac_ddata,
  input  logic                  clr_count,
  output logic                  underflow,
  output logic [31:0]           underflow_count,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_LVL   = LW'(1 << DEPTH_LOG2);
  localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);

  dma_buf_state_t        r_state;
  dma_buf_state_t        w_state_nxt;
  logic [LW-1:0]         r_wr_ptr;
  logic [LW-1:0]         r_rd_ptr;
  logic                  r_s_ready;
  logic [31:0]           r_underflow_count;
  logic [LW-1:0]         w_level;
  logic [LW-1:0]         w_level_nxt;
  logic                  w_push;
  logic                  w_active;
  logic                  w_pop;
  logic                  w_underflow;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Pointers carry one extra MSB, so their difference spans 0..depth without ambiguity.
  assign w_level     = r_wr_ptr - r_rd_ptr;
  assign w_push      = s_valid & r_s_ready;
  assign w_active    = (r_state == ST_RUN) & dac_valid & ~dac_rst & ~reset;
  assign w_pop       = w_active & (w_level != {LW{1'b0}});
  assign w_underflow = w_active & (w_level == {LW{1'b0}});
  assign w_level_nxt = w_level + {{(LW-1){1'b0}}, w_push} - {{(LW-1){1'b0}}, w_pop};

  // Playout state sequencing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_PREFILL;
      end
      ST_PREFILL: begin
        if (w_level >= PREFILL_LVL) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_PREFILL;
        end
      end
      ST_RUN: begin
        if (w_underflow) begin
          w_state_nxt = ST_PREFILL;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pointers and ready; a flush empties the FIFO and drops any coincident push.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= {LW{1'b0}};
      r_rd_ptr  <= {LW{1'b0}};
      r_s_ready <= 1'b0;
    end else if (dac_rst) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= {LW{1'b0}};
      r_rd_ptr  <= {LW{1'b0}};
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_ptr  <= r_wr_ptr + {{(LW-1){1'b0}}, w_push};
      r_rd_ptr  <= r_rd_ptr + {{(LW-1){1'b0}}, w_pop};
      r_s_ready <= (w_level_nxt < DEPTH_LVL);
    end
  end

  // Underflow counter; clearing wins over a coincident event and it survives flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_underflow_count <= 32'd0;
    end else if (clr_count) begin
      r_underflow_count <= 32'd0;
    end else if (w_underflow) begin
      r_underflow_count <= sat_inc32(r_underflow_count);
    end
  end

  ad_ip_jesd204_tpl_dac_dma_buffer_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push & ~dac_rst & ~reset),
    .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wdata (s_data),
    .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rdata (w_rdata)
  );

  assign s_ready         = r_s_ready;
  assign dac_ddata       = w_pop ? w_rdata : {DATA_WIDTH{1'b0}};
  assign underflow       = w_underflow;
  assign underflow_count = r_underflow_count;
  assign level           = w_level;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_dma_buffer.sv
// Directed bench for the DAC DMA buffer: a queue-based playout model checked every cycle,
// plus hand-computed expectations for prefill, underflow, full, flush and counter cases.
module tb_ad_ip_jesd204_tpl_dac_dma_buffer;

  localparam int DW    = 128;
  localparam int DL2   = 4;
  localparam int PF    = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset, s_valid, dac_valid, dac_rst, clr_count;
  logic          s_ready, underflow;
  logic [DW-1:0] s_data, dac_ddata;
  logic [31:0]   underflow_count;
  logic [DL2:0]  level;

  int checks = 0;
  int errors = 0;

  // Model: queue contents, mode 0=idle 1=prefill 2=run, counter, ready flag.
  logic [DW-1:0] mq[$];
  int            mmode = 0;
  logic [31:0]   mcnt = 32'd0;
  bit            mready = 1'b0;
  bit            mvalid = 1'b0;

  logic [DW-1:0] last_dd;
  logic          last_uf, last_rdy;
  logic [31:0]   last_cnt;
  logic [DL2:0]  last_lvl;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_dma_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH_LOG2 (DL2),
    .PREFILL    (PF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .dac_valid       (dac_valid),
    .dac_rst         (dac_rst),
    .dac_ddata       (dac_ddata),
    .clr_count       (clr_count),
    .underflow       (underflow),
    .underflow_count (underflow_count),
    .level           (level)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then advance the model.
  task automatic step(input bit rst, input bit sv, input logic [DW-1:0] sd,
                      input bit dv, input bit dr, input bit clr);
    bit            active, pop, uf, push;
    logic [DW-1:0] edd;
    int            old;
    @(negedge clk);
    reset = rst; s_valid = sv; s_data = sd; dac_valid = dv; dac_rst = dr; clr_count = clr;
    #1;
    active = (mmode == 2) && dv && !dr && !rst;
    pop    = active && (mq.size() > 0);
    uf     = active && (mq.size() == 0);
    edd    = pop ? mq[0] : '0;
    if (mvalid) begin
      chk("level", 128'(level), 128'(mq.size()));
      chk("s_ready", 128'(s_ready), 128'(mready));
      chk("dac_ddata", dac_ddata, edd);
      chk("underflow", 128'(underflow), 128'(uf));
      chk("underflow_count", 128'(underflow_count), 128'(mcnt));
    end
    last_dd = dac_ddata; last_uf = underflow; last_rdy = s_ready;
    last_cnt = underflow_count; last_lvl = level;
    if (rst) begin
      mq.delete(); mmode = 0; mcnt = 32'd0; mready = 1'b0; mvalid = 1'b1;
    end else begin
      old = mq.size();
      if (clr) mcnt = 32'd0;
      else if (uf && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
      if (dr) begin
        mq.delete(); mmode = 0; mready = 1'b0;
      end else begin
        push = sv && mready;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(sd);
        case (mmode)
          0: mmode = 1;
          1: if (old >= PF) mmode = 2;
          2: if (uf) mmode = 1;
          default: mmode = 0;
        endcase
        mready = (mq.size() < DEPTH);
      end
    end
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; dac_valid = 1'b0; dac_rst = 1'b0; clr_count = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_level", 128'(last_lvl), 128'd0);
    chk("rst_ready", 128'(last_rdy), 128'd0);
    chk("rst_count", 128'(last_cnt), 128'd0);
    chk("rst_ddata", last_dd, 128'd0);

    // Prefill then underflow with dac_valid held high throughout.
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 128'hA, 1, 0, 0);
    step(0, 1, 128'hB, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("pf_wait_dd", last_dd, 128'd0);
    chk("pf_wait_lvl", 128'(last_lvl), 128'd2);
    step(0, 0, 0, 1, 0, 0);
    chk("pf_word_a", last_dd, 128'hA);
    step(0, 0, 0, 1, 0, 0);
    chk("pf_word_b", last_dd, 128'hB);
    step(0, 0, 0, 1, 0, 0);
    chk("uf_dd", last_dd, 128'd0);
    chk("uf_pulse", 128'(last_uf), 128'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("uf_count", 128'(last_cnt), 128'd1);
    chk("uf_single", 128'(last_uf), 128'd0);

    // Fill to full with 20 offered words, then one pop frees a slot.
    for (int i = 0; i < 20; i++) step(0, 1, 128'h100 + 128'(i), 0, 0, 0);
    chk("full_lvl", 128'(last_lvl), 128'd16);
    chk("full_ready", 128'(last_rdy), 128'd0);
    step(0, 1, 128'h200, 1, 0, 0);
    chk("full_pop", last_dd, 128'h100);
    step(0, 1, 128'h200, 0, 0, 0);
    chk("full_refill_lvl", 128'(last_lvl), 128'd15);
    chk("full_refill_rdy", 128'(last_rdy), 128'd1);

    // Drain to 5, then push and pop every cycle.
    for (int i = 0; i < 40 && mq.size() > 5; i++) step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 1, 128'h300 + 128'(i), 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pp_lvl", 128'(last_lvl), 128'd5);
    step(0, 0, 0, 1, 0, 0);
    chk("pp_order", last_dd, 128'h35F);

    // Flush at level 8.
    for (int i = 0; i < 4; i++) step(0, 1, 128'h400 + 128'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_flush_lvl", 128'(last_lvl), 128'd8);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("flush_lvl", 128'(last_lvl), 128'd0);
    chk("flush_ready", 128'(last_rdy), 128'd0);
    chk("flush_dd", last_dd, 128'd0);
    chk("flush_count", 128'(last_cnt), 128'd1);
    step(0, 1, 128'h500, 1, 0, 0);
    chk("flush_prefill_rdy", 128'(last_rdy), 128'd1);
    step(0, 1, 128'h501, 1, 0, 0);

    // Saturation: preload the counter, then underflow.
    force dut.r_underflow_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_underflow_count;
    mcnt = 32'hFFFF_FFFF;
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("sat_uf", 128'(last_uf), 128'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("sat_count", 128'(last_cnt), 128'hFFFF_FFFF);

    // Clear coincident with an underflow.
    step(0, 1, 128'h600, 0, 0, 0);
    step(0, 1, 128'h601, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    chk("clr_uf", 128'(last_uf), 128'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("clr_count", 128'(last_cnt), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_dma_buffer.md
AD_IP_JESD204_TPL_DAC_DMA_BUFFER -- requirements
Module: ad_ip_jesd204_tpl_dac_dma_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: word width, equal to the TPL DAC link data width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 words.
REQ-003 SHALL have parameter PREFILL, default 2: minimum level (1..depth) required to start or restart playout.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-005 SHALL have port clk, input, 1: the single clock for all logic.
REQ-006 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have port s_valid, input, 1: DMA word valid.
REQ-008 SHALL have port s_ready, output, 1: buffer can accept a DMA word.
REQ-009 SHALL have port s_data, input, DATA_WIDTH: DMA word.
REQ-010 SHALL have port dac_valid, input, 1: TPL consumes one word this cycle.
REQ-011 SHALL have port dac_rst, input, 1: TPL flush request.
REQ-012 SHALL have port dac_ddata, output, DATA_WIDTH: word presented to the TPL.
REQ-013 SHALL have port clr_count, input, 1: clears underflow_count.
REQ-014 SHALL have port underflow, output, 1: single-cycle underflow pulse.
REQ-015 SHALL have port underflow_count, output, 32: saturating count of underflow events.
REQ-016 SHALL have port level, output, DEPTH_LOG2+1: current fill level.

Function
REQ-017 SHALL implement a FIFO with push = s_valid & s_ready and s_ready = (level < 2**DEPTH_LOG2); s_ready SHALL depend only on registered state.
REQ-018 SHALL update level each cycle by +push, -pop; push and pop in the same cycle SHALL leave level unchanged.
REQ-019 SHALL implement states IDLE, PREFILL and RUN; reset and dac_rst SHALL enter IDLE.
REQ-020 SHALL transition IDLE->PREFILL on the first cycle after reset or dac_rst is deasserted.
REQ-021 SHALL transition PREFILL->RUN when the registered level >= PREFILL.
REQ-022 SHALL pop only in RUN, only when dac_valid=1 and level>0; dac_ddata SHALL be the head word (first-word-fall-through) in the same cycle as the pop.
REQ-023 SHALL drive dac_ddata = 0 in IDLE and PREFILL, and whenever no pop occurs.
REQ-024 SHALL, in RUN with dac_valid=1 and level=0: drive dac_ddata = 0, assert underflow for exactly that cycle, increment underflow_count (saturating at 0xFFFFFFFF), and transition to PREFILL. A simultaneous push SHALL be stored; there is no bypass.
REQ-025 SHALL ignore dac_valid outside RUN: no pop, no underflow.
REQ-026 SHALL handle dac_rst as follows: while asserted, discard FIFO contents (level=0, pointers equal) and hold s_ready=0; underflow_count is retained.
REQ-027 SHALL clear underflow_count when clr_count=1; clr_count SHALL take priority over a coincident increment.
REQ-028 SHALL wrap read and write pointers modulo depth, using an extra MSB to distinguish full from empty.

Reset
REQ-029 SHALL, on reset=1 at a clk edge, set state=IDLE, level=0, pointers=0, s_ready=0, underflow=0 and underflow_count=0; dac_ddata SHALL be 0 from that edge.
REQ-030 SHALL give reset priority over dac_rst, clr_count and all handshakes; FIFO storage contents need not be reset.

Structure
REQ-031 SHALL place the state encoding (IDLE/PREFILL/RUN) and the count-saturation constant in the shared TPL DAC package.
REQ-032 SHALL put storage in one sub-module, ad_ip_jesd204_tpl_dac_dma_buffer_mem: simple dual-port RAM with asynchronous read (distributed), no reset; control logic stays in the top.

Verification
REQ-033 SHALL cover prefill: PREFILL=2; push 0xA, 0xB with dac_valid=1 throughout -> dac_ddata=0 until level reaches 2, then 0xA, then 0xB on consecutive cycles.
REQ-034 SHALL cover underflow: in RUN with 1 word left, hold dac_valid=1 for 2 cycles -> word output, then dac_ddata=0, underflow pulse, underflow_count=1, state PREFILL.
REQ-035 SHALL cover full: depth 16, no dac_valid, push 20 words -> s_ready=0 after the 16th, level=16, words 17-20 not accepted until a pop.
REQ-036 SHALL cover simultaneous push/pop: in RUN at level 5 with push and pop every cycle for 100 cycles -> level stays 5 and data order is preserved.
REQ-037 SHALL cover dac_rst mid-run: at level 8, pulse dac_rst for 1 cycle -> level=0, dac_ddata=0, underflow_count unchanged, state IDLE then PREFILL.
REQ-038 SHALL cover the counter: force underflow_count to 0xFFFFFFFF and trigger underflow -> count stays saturated; clr_count coincident with underflow -> count=0.
